// File: rtl/mem_write_tracer.sv
// mem_write_tracer: snoops data-memory writes, counts them per address window and queues matched ones as trace entries.
// Define TRACE_PC_EN to store the PC with each entry; otherwise trace_pc_o is tied to 0.
module mem_write_tracer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NUM_REGIONS = 2,
  parameter int FIFO_DEPTH = 16,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {32'd262144, 32'd0},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LIMIT = {32'hFFFFFFFF, 32'd4095},
  localparam int RW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1,
  localparam int LW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [ADDR_W-1:0]           data_mem_address_i,
  input  logic [DATA_W-1:0]           data_mem_in_data_i,
  input  logic                        data_mem_WE_i,
  input  logic [ADDR_W-1:0]           inst_mem_address_i,
  input  logic                        enable_i,
  input  logic                        clear_i,
  output logic                        trace_valid_o,
  input  logic                        trace_ready_i,
  output logic [RW-1:0]               trace_region_o,
  output logic [ADDR_W-1:0]           trace_offset_o,
  output logic [DATA_W-1:0]           trace_data_o,
  output logic [ADDR_W-1:0]           trace_pc_o,
  output logic [NUM_REGIONS*32-1:0]   region_count_o,
  output logic [31:0]                 miss_count_o,
  output logic [31:0]                 drop_count_o,
  output logic                        overflow_o,
  output logic [LW-1:0]               fifo_level_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
`ifdef TRACE_PC_EN
  localparam int EW = RW + 2*ADDR_W + DATA_W;
`else
  localparam int EW = RW + ADDR_W + DATA_W;
`endif

  logic              w_hit;
  logic [RW-1:0]     w_idx;
  logic [ADDR_W-1:0] w_base;
  logic [PW:0]       r_wptr, r_rptr, w_level;
  logic              w_valid, w_full, w_cap, w_pop, w_push, w_drop, w_miss;
  logic [EW-1:0]     r_mem [FIFO_DEPTH];
  logic [EW-1:0]     w_entry, w_head;
  logic [31:0]       r_cnt [NUM_REGIONS];
  logic [31:0]       r_miss, r_drop;
  logic              r_ovf;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return v + {31'd0, ~&v};
  endfunction

  // Descending scan so the lowest matching region is the one left standing.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    w_base = '0;
    for (int k = NUM_REGIONS - 1; k >= 0; k--)
      if (data_mem_address_i >= REGION_BASE[k*ADDR_W +: ADDR_W] &&
          data_mem_address_i <= REGION_LIMIT[k*ADDR_W +: ADDR_W]) begin
        w_hit = 1'b1;
        w_idx = RW'(k);
        w_base = REGION_BASE[k*ADDR_W +: ADDR_W];
      end
  end

  assign w_level = r_wptr - r_rptr;
  assign w_valid = r_wptr != r_rptr;
  assign w_full  = w_level[PW];
  assign w_cap   = data_mem_WE_i & enable_i & ~clear_i;
  assign w_pop   = w_valid & trace_ready_i & ~clear_i;
  assign w_push  = w_cap & w_hit & (~w_full | w_pop);
  assign w_drop  = w_cap & w_hit & w_full & ~w_pop;
  assign w_miss  = w_cap & ~w_hit;
  assign w_head  = w_valid ? r_mem[r_rptr[PW-1:0]] : '0;

`ifdef TRACE_PC_EN
  assign w_entry = {inst_mem_address_i, w_idx, data_mem_address_i - w_base, data_mem_in_data_i};
  assign {trace_pc_o, trace_region_o, trace_offset_o, trace_data_o} = w_head;
`else
  logic w_unused_pc;
  assign w_unused_pc = ^inst_mem_address_i;
  assign w_entry = {w_idx, data_mem_address_i - w_base, data_mem_in_data_i};
  assign {trace_region_o, trace_offset_o, trace_data_o} = w_head;
  assign trace_pc_o = '0;
`endif

  assign trace_valid_o = w_valid;
  assign fifo_level_o  = LW'(w_level);
  assign miss_count_o  = r_miss;
  assign drop_count_o  = r_drop;
  assign overflow_o    = r_ovf;

  for (genvar k = 0; k < NUM_REGIONS; k++) begin : g_cnt
    assign region_count_o[k*32 +: 32] = r_cnt[k];
  end

  always_ff @(posedge CLK)
    if (w_push) r_mem[r_wptr[PW-1:0]] <= w_entry;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_miss <= '0;
      r_drop <= '0;
      r_ovf  <= 1'b0;
      for (int k = 0; k < NUM_REGIONS; k++) r_cnt[k] <= '0;
    end else if (clear_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_miss <= '0;
      r_drop <= '0;
      r_ovf  <= 1'b0;
      for (int k = 0; k < NUM_REGIONS; k++) r_cnt[k] <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_cap & w_hit) r_cnt[w_idx] <= sat_inc(r_cnt[w_idx]);
      if (w_miss) r_miss <= sat_inc(r_miss);
      if (w_drop) begin
        r_drop <= sat_inc(r_drop);
        r_ovf  <= 1'b1;
      end
    end
  end
endmodule

// File: doc/mem_write_tracer.md
# mem_write_tracer

Synthesizable snooper on the CPU data-memory write bus. Classifies each write into one of `NUM_REGIONS` address windows and counts writes per region. Buffers matched writes as trace entries (region, offset, data, PC) in a FIFO drained over a valid/ready port. Sits beside `DataMemoryManager` on the same bus and replaces per-window write logging done in simulation only.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, write-data width
- `NUM_REGIONS`, 2, number of address windows, 1..8
- `FIFO_DEPTH`, 16, trace entries, power of 2, ≥2
- `REGION_BASE`, {262144, 0}, packed `NUM_REGIONS*ADDR_W`, inclusive base per region (region 0 in LSBs)
- `REGION_LIMIT`, {32'hFFFFFFFF, 4095}, packed, inclusive limit per region
- `CLK` in 1 — single clock, rising edge
- `RST` in 1 — reset, asynchronous, active-low
- `data_mem_address_i` in `ADDR_W` — bus address
- `data_mem_in_data_i` in `DATA_W` — bus write data
- `data_mem_WE_i` in 1 — bus write enable
- `inst_mem_address_i` in `ADDR_W` — current PC
- `enable_i` in 1 — capture enable
- `clear_i` in 1 — synchronous clear of FIFO, counters and flags
- `trace_valid_o` out 1 — FIFO head valid
- `trace_ready_i` in 1 — consumer accepts head
- `trace_region_o` out RW — region index, RW = max(1, clog2(NUM_REGIONS))
- `trace_offset_o` out `ADDR_W` — address − base of the matched region
- `trace_data_o` out `DATA_W` — write data
- `trace_pc_o` out `ADDR_W` — PC at capture
- `region_count_o` out `NUM_REGIONS*32` — per-region write counts
- `miss_count_o` out 32 — enabled writes matching no region
- `drop_count_o` out 32 — matched writes lost to a full FIFO
- `overflow_o` out 1 — sticky, set on first drop
- `fifo_level_o` out clog2(FIFO_DEPTH+1) — occupancy

## Operation
- Capture event: rising edge with `data_mem_WE_i`=1, `enable_i`=1 and `clear_i`=0.
- Region match: `REGION_BASE[k]` ≤ addr ≤ `REGION_LIMIT[k]`, unsigned. When regions overlap, the lowest k wins.
- Matched event:
  - increments `region_count_o[k]`;
  - pushes {k, addr−base[k], data, PC} into the FIFO. Offset is the `ADDR_W`-bit unsigned difference.
- Unmatched event: increments `miss_count_o`. Nothing is pushed.
- All counters saturate at 32'hFFFFFFFF and never wrap.
- FIFO is first-word-fall-through:
  - `trace_*` show the head while `trace_valid_o`=1.
  - Pop on a rising edge with `trace_valid_o`=1 and `trace_ready_i`=1.
  - Trace outputs are don't-care while empty.
- Full FIFO with a matched event:
  - With a same-cycle pop: push and pop both occur, level stays `FIFO_DEPTH`, no drop.
  - Without a pop: entry discarded, `drop_count_o`+1, `overflow_o`←1. `region_count_o[k]` still increments.
- Empty FIFO with push: the entry is valid the next cycle. No bypass to the same cycle.
- Read/write pointers are clog2(`FIFO_DEPTH`)+1 bits and wrap naturally.
- `clear_i`=1:
  - next edge sets the FIFO empty, all counters to 0 and `overflow_o` to 0;
  - overrides any same-cycle capture or pop.
- `enable_i`=0: bus ignored. Draining continues.

## Timing
- Reset (`RST`=0, async): `trace_valid_o`=0, `fifo_level_o`=0, all counts 0, `overflow_o`=0, pointers 0. Trace data outputs are 0.
- Reset mid-operation drops all buffered entries immediately. Release is synchronous to `CLK`.
- Latency: a write sampled at edge N gives `trace_valid_o`=1 and updated counters after edge N.
- `fifo_level_o` updates on the same edge as the push/pop that changes it.
- No combinational path from `trace_ready_i` to `trace_valid_o`. The bus inputs are registered-sampled only.

## Configuration
- `TRACE_PC_EN` defined: the PC is stored per entry and `trace_pc_o` carries the captured PC.
- Not defined: the PC is not stored, the FIFO word narrows by `ADDR_W`, `trace_pc_o` is tied to 0, and `inst_mem_address_i` is unused.

## Test plan
- Defaults, `enable_i`=1, one write addr 100 data 7 → one entry {region 0, offset 100, data 7}; `region_count_o[0]`=1.
- Write addr 262150 data 255 → entry {region 1, offset 6, data 255}; write addr 5000 → `miss_count_o`=1, no entry.
- 17 matched writes, `trace_ready_i`=0 → `fifo_level_o`=16, `drop_count_o`=1, `overflow_o`=1; draining returns the first 16 in order.
- FIFO full, matched write plus pop in the same cycle → level stays 16, `drop_count_o` unchanged, new entry arrives last.
- `clear_i` asserted in the same cycle as a matched write → after the edge the level is 0, all counts are 0 and `overflow_o`=0.
- `RST` pulsed low between edges with 5 entries buffered → `trace_valid_o`=0 immediately. With `TRACE_PC_EN`, `trace_pc_o` equals the PC present at capture.
